// File: rtl/aes_inv_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryptor.
`timescale 1ns/1ps
package aes_inv_pkg;

  localparam int NR     = 10;
  localparam int NK_BUF = NR + 1;

  typedef enum logic [1:0] {IDLE, KEXP, READY, DEC} state_t;
  typedef logic [127:0] rk_t;

  // Forward S-box, byte 0 in the MSBs; used by the key schedule.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[{~a, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // One column of InvMixColumns; s0 is the row-0 byte.
  function automatic logic [31:0] inv_mix_col(input logic [7:0] s0, s1, s2, s3);
    return {gmule(s0) ^ gmulb(s1) ^ gmuld(s2) ^ gmul9(s3),
            gmul9(s0) ^ gmule(s1) ^ gmulb(s2) ^ gmuld(s3),
            gmuld(s0) ^ gmul9(s1) ^ gmule(s2) ^ gmulb(s3),
            gmulb(s0) ^ gmuld(s1) ^ gmul9(s2) ^ gmule(s3)};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box: pure combinational table lookup.
`timescale 1ns/1ps
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] b
);

  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  assign b = INV_TBL[{~a, 3'b111} -: 8];

endmodule

// File: rtl/aes_key_expand_128.sv
// AES-128 key schedule, one round key per clock; wo_* show rk_i in the i-th cycle after kld.
`timescale 1ns/1ps
module aes_key_expand_128
  import aes_inv_pkg::*;
(
  input  logic         clk,
  input  logic         kld,
  input  logic [127:0] key,
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3
);

  logic [31:0] w0, w1, w2, w3, t;
  logic [7:0]  rcon;

  assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};

  // Load the cipher key, then advance one round key per edge.
  always_ff @(posedge clk) begin
    if (kld) begin
      {w0, w1, w2, w3} <= key;
      rcon <= 8'h01;
    end else begin
      w0   <= w0 ^ t;
      w1   <= w0 ^ w1 ^ t;
      w2   <= w0 ^ w1 ^ w2 ^ t;
      w3   <= w0 ^ w1 ^ w2 ^ w3 ^ t;
      rcon <= xtime(rcon);
    end
  end

  assign wo_0 = w0;
  assign wo_1 = w1;
  assign wo_2 = w2;
  assign wo_3 = w3;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: expands the key once into an 11-entry buffer,
// then decrypts blocks one round per clock using the keys in reverse order.
`timescale 1ns/1ps
module aes_inv_cipher_iter
  import aes_inv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic         kdone,
  output logic         kvalid,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic         done,
  output logic         busy,
  output logic [127:0] text_out
);

  state_t      fsm;
  logic [3:0]  kcnt, dcnt, rsel;
  logic [31:0] wo_0, wo_1, wo_2, wo_3;
  rk_t         rk [NK_BUF];
  rk_t         st, text_in_r;
  logic [127:0] isr, isb, ark, imc;

  aes_key_expand_128 u_kexp (
    .clk (clk), .kld (kld), .key (key),
    .wo_0(wo_0), .wo_1(wo_1), .wo_2(wo_2), .wo_3(wo_3)
  );

  // Round key for the current step: rk10 first, rk0 last.
  assign rsel = 4'(NR) - dcnt;

  // InvShiftRows (row r rotates right by r) feeding the 16 inverse S-boxes.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int R   = i % 4;
    localparam int C   = i / 4;
    localparam int SRC = ((C - R + 4) % 4) * 4 + R;
    assign isr[127-8*i -: 8] = st[127-8*SRC -: 8];
    aes_inv_sbox u_sbox (.a(isr[127-8*i -: 8]), .b(isb[127-8*i -: 8]));
  end

  assign ark = isb ^ rk[rsel];

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 8], ark[119-32*c -: 8],
                                             ark[111-32*c -: 8], ark[103-32*c -: 8]);
  end

  // Capture one round key per KEXP cycle; the buffer survives until the next kld.
  always_ff @(posedge clk) begin
    if (fsm == KEXP && !kld) rk[kcnt] <= {wo_0, wo_1, wo_2, wo_3};
  end

  // Control FSM with registered status outputs; kld preempts everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= IDLE;
      kcnt      <= '0;
      dcnt      <= '0;
      kdone     <= 1'b0;
      kvalid    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      text_out  <= '0;
      text_in_r <= '0;
      st        <= '0;
    end else begin
      kdone <= 1'b0;
      done  <= 1'b0;
      if (kld) begin
        fsm    <= KEXP;
        kcnt   <= '0;
        kvalid <= 1'b0;
        busy   <= 1'b1;
      end else begin
        case (fsm)
          KEXP: begin
            kcnt <= kcnt + 4'd1;
            if (kcnt == 4'(NR)) begin
              fsm    <= READY;
              kdone  <= 1'b1;
              kvalid <= 1'b1;
              busy   <= 1'b0;
            end
          end
          READY: begin
            if (ld) begin
              fsm       <= DEC;
              text_in_r <= text_in;
              dcnt      <= '0;
              busy      <= 1'b1;
            end
          end
          DEC: begin
            if (ld) begin
              // A new block replaces the one in flight.
              text_in_r <= text_in;
              dcnt      <= '0;
            end else begin
              dcnt <= dcnt + 4'd1;
              if (dcnt == 4'd0) begin
                st <= text_in_r ^ rk[NR];
              end else if (dcnt == 4'(NR)) begin
                text_out <= ark;
                done     <= 1'b1;
                fsm      <= READY;
                busy     <= 1'b0;
              end else begin
                st <= imc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
